// File: rtl/binary_matvec_seq_pkg.sv
`default_nettype none
// ===================================================================
// binary_matvec_seq_pkg: shared state encoding and clog2 helper
// Revision: 1.0
// ===================================================================
package binary_matvec_seq_pkg;

  typedef enum logic [1:0] {
    S_ROWS = 2'd0,
    S_VEC  = 2'd1,
    S_COMP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/binary_matvec_seq_row_dot.sv
`default_nettype none
// ===================================================================
// binary_row_dot: combinational dot product of one row with the vector
// Revision: 1.0
// ===================================================================
module binary_row_dot #(
  parameter int N         = 4,
  parameter int OR_REDUCE = 0
) (
  input  logic [N-1:0] row,
  input  logic [N-1:0] vec,
  output logic         dot
);

  logic [N-1:0] prod;
  assign prod = row & vec;

  generate
    if (OR_REDUCE != 0) begin : g_or
      assign dot = |prod;
    end else begin : g_xor
      assign dot = ^prod;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/binary_matvec_seq.sv
`default_nettype none
// ===================================================================
// binary_matvec_seq: serial-load N x N binary matrix-vector sequencer
// Revision: 1.0
// ===================================================================
module binary_matvec_seq
  import binary_matvec_seq_pkg::*;
#(
  parameter int N         = 4,
  parameter int OR_REDUCE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         row_valid,
  output logic         row_ready,
  input  logic [N-1:0] row_data,
  input  logic         vec_valid,
  output logic         vec_ready,
  input  logic [N-1:0] vec_data,
  input  logic         reuse_mat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int            IW   = clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] row_idx;
  logic [N-1:0]  mat [N];
  logic [N-1:0]  vec;
  logic          dot;

  assign row_ready = (state == S_ROWS);
  assign vec_ready = (state == S_VEC);

  // Single shared dot unit, steered to the current row by row_idx.
  binary_row_dot #(
    .N         (N),
    .OR_REDUCE (OR_REDUCE)
  ) u_row_dot (
    .row (mat[row_idx]),
    .vec (vec),
    .dot (dot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ROWS;
      row_idx   <= '0;
      vec       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < N; i++) mat[i] <= '0;
    end else begin
      case (state)
        S_ROWS: begin
          if (row_valid) begin
            mat[row_idx] <= row_data;
            if (row_idx == LAST) begin
              row_idx <= '0;
              state   <= S_VEC;
            end else begin
              row_idx <= row_idx + IW'(1);
            end
          end
        end
        S_VEC: begin
          if (vec_valid) begin
            vec     <= vec_data;
            row_idx <= '0;
            busy    <= 1'b1;
            state   <= S_COMP;
          end
        end
        S_COMP: begin
          out_data[row_idx] <= dot;
          if (row_idx == LAST) begin
            row_idx   <= '0;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            row_idx <= row_idx + IW'(1);
          end
        end
        S_OUT: begin
          // out_data is left untouched so it stays readable after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= reuse_mat ? S_VEC : S_ROWS;
          end
        end
        default: state <= S_ROWS;
      endcase
    end
  end

endmodule
`default_nettype wire
